// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-master unified-RAM data port arbiter.
package ram_port_arbiter_pkg;

    localparam int unsigned RAM_BYTES  = 4096;
    localparam int unsigned DEF_ADDR_W = $clog2(RAM_BYTES);

    typedef enum logic {
        M_CORE   = 1'b0,
        M_LOADER = 1'b1
    } master_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    // Anything above the implemented byte-address width is out of range.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned addr_w);
        return (addr >> addr_w) == 32'd0;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester's request/response bundle into the RAM port arbiter.
interface ram_port_arbiter_if;
    logic        req;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, be, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-input round-robin picker; FIXED_P=1 makes input 0 win every tie.
module rr_arb2
    import ram_port_arbiter_pkg::*;
#(
    parameter bit FIXED_P = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    master_e    prio_q, prio_d;
    logic [1:0] req_v;

    always_comb begin
        // Nothing is granted while reset is held.
        req_v  = req_i & {2{rst_ni}};
        gnt_o  = '0;
        prio_d = prio_q;
        unique case (req_v)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (FIXED_P || prio_q == M_CORE) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            prio_d = M_LOADER;
        end else if (gnt_o[1]) begin
            prio_d = M_CORE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= M_CORE;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the byte-enabled unified-RAM data port between the core (M0) and the loader (M1).
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter bit          FIXED_P = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ram_port_arbiter_if.slave m0_if,
    ram_port_arbiter_if.slave m1_if,
    output logic              mem_en_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    logic [1:0]  req, gnt;
    logic        any_gnt, in_range;
    logic [3:0]  win_be;
    logic [31:0] win_addr, win_wdata;
    owner_e      owner_q, owner_d;
    logic        err_q, err_d;

    assign req = {m1_if.req, m0_if.req};

    rr_arb2 #(.FIXED_P(FIXED_P)) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req),
        .gnt_o  (gnt)
    );

    assign m0_if.gnt = gnt[0];
    assign m1_if.gnt = gnt[1];
    assign any_gnt   = |gnt;

    always_comb begin
        win_be    = gnt[1] ? m1_if.be    : m0_if.be;
        win_addr  = gnt[1] ? m1_if.addr  : m0_if.addr;
        win_wdata = gnt[1] ? m1_if.wdata : m0_if.wdata;
    end

    // Out-of-range accesses are still granted so the requester gets an error response.
    assign in_range    = addr_in_range(win_addr, ADDR_W);
    assign mem_en_o    = any_gnt & in_range;
    assign mem_be_o    = mem_en_o ? win_be : '0;
    assign mem_addr_o  = {win_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata_o = win_wdata;

    always_comb begin
        owner_d = OWN_NONE;
        err_d   = 1'b0;
        if (any_gnt) begin
            owner_d = gnt[1] ? OWN_M1 : OWN_M0;
            err_d   = !in_range;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign m0_if.rvalid = (owner_q == OWN_M0);
    assign m1_if.rvalid = (owner_q == OWN_M1);
    assign m0_if.err    = m0_if.rvalid & err_q;
    assign m1_if.err    = m1_if.rvalid & err_q;
    assign m0_if.rdata  = (m0_if.rvalid && !err_q) ? mem_rdata_i : '0;
    assign m1_if.rdata  = (m1_if.rvalid && !err_q) ? mem_rdata_i : '0;

endmodule
